// File: rtl/pipelined_carry_select_subtractor.sv
// Two-stage carry-select subtractor: diff = a - b computed as a + ~b + 1.
// Stage 1 forms both upper-half candidates; stage 2 picks one and derives borrow/overflow.
module pipelined_carry_select_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int HALF = WIDTH / 2;

  function automatic logic [HALF:0] half_add(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic            cin);
    return {1'b0, x} + {1'b0, y} + {{HALF{1'b0}}, cin};
  endfunction

  logic [HALF:0]   lo_sum_p0, hi0_sum_p0, hi1_sum_p0;
  logic [HALF-1:0] lo_p1, hi0_p1, hi1_p1;
  logic            c_lo_p1, c0_p1, c1_p1;
  logic            a_msb_p1, b_msb_p1;
  logic            vld_p1;
  logic            s2_free;
  logic [HALF-1:0] hi_sel_p1;
  logic            cout_p1;
  logic            ov_p1;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_free;

  // Stage 0 -> 1: exact lower half, speculative upper halves for both carry-ins
  always_comb begin
    lo_sum_p0  = half_add(a[HALF-1:0],     ~b[HALF-1:0],     1'b1);
    hi0_sum_p0 = half_add(a[WIDTH-1:HALF], ~b[WIDTH-1:HALF], 1'b0);
    hi1_sum_p0 = half_add(a[WIDTH-1:HALF], ~b[WIDTH-1:HALF], 1'b1);
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      lo_p1    <= lo_sum_p0[HALF-1:0];
      c_lo_p1  <= lo_sum_p0[HALF];
      hi0_p1   <= hi0_sum_p0[HALF-1:0];
      c0_p1    <= hi0_sum_p0[HALF];
      hi1_p1   <= hi1_sum_p0[HALF-1:0];
      c1_p1    <= hi1_sum_p0[HALF];
      a_msb_p1 <= a[WIDTH-1];
      b_msb_p1 <= b[WIDTH-1];
    end
  end

  // Stage 1 -> 2: lower-half carry selects the upper candidate
  always_comb begin
    hi_sel_p1 = c_lo_p1 ? hi1_p1 : hi0_p1;
    cout_p1   = c_lo_p1 ? c1_p1  : c0_p1;
    ov_p1     = (a_msb_p1 != b_msb_p1) && (hi_sel_p1[HALF-1] != a_msb_p1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else if (s2_free && vld_p1) begin
      diff     <= {hi_sel_p1, lo_p1};
      borrow   <= ~cout_p1;
      overflow <= ov_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s2_free)  out_valid <= vld_p1;
      if (in_ready) vld_p1    <= in_valid;
    end
  end

endmodule

// File: tb/tb_pipelined_carry_select_subtractor.sv
// Scoreboard bench for pipelined_carry_select_subtractor: driver queues expected results,
// a negedge monitor pops and compares them whenever a result transfers.
module tb_pipelined_carry_select_subtractor;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, borrow, overflow;
  logic [31:0] a, b, diff;

  pipelined_carry_select_subtractor #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        bw;
    logic        ov;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  bit          saw_block = 0;
  bit          held = 0;
  logic [31:0] hd;
  logic        hbw, hov;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, req);
    else passed++;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && !in_ready) saw_block = 1;
      if (held) begin
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_diff", diff, hd);
        chk("stall_flags", {30'b0, borrow, overflow}, {30'b0, hbw, hov});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_output: got diff 0x%h, expected no result", diff);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("diff", diff, e.d);
          chk("borrow", {31'b0, borrow}, {31'b0, e.bw});
          chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
          if (e.lat) chk("latency", cyc - e.acc, 32'd2);
          pop_cyc.push_back(cyc);
        end
      end
      held = out_valid && !out_ready;
      hd = diff; hbw = borrow; hov = overflow;
    end
  end

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [31:0] d,
                      input logic bw, input logic ov, input bit lat);
    bit ok;
    exp_t e;
    ok = 0;
    a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.d = d; e.bw = bw; e.ov = ov; e.acc = cyc; e.lat = lat;
        sb.push_back(e);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_empty", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_diff", diff, 32'd0);
    chk("reset_flags", {30'b0, borrow, overflow}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed arithmetic vectors, back-to-back with no backpressure
    push(32'd5,        32'd3,        32'h00000002, 1'b0, 1'b0, 1);
    push(32'h1234ABCD, 32'h1234ABCD, 32'h00000000, 1'b0, 1'b0, 1);
    push(32'd3,        32'd5,        32'hFFFFFFFE, 1'b1, 1'b0, 1);
    push(32'd0,        32'd1,        32'hFFFFFFFF, 1'b1, 1'b0, 1);
    push(32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b0, 1);
    push(32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1);
    push(32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 1);
    in_valid = 1'b0;
    drain();

    // Backpressure: stall the output while four operands stream in
    saw_block = 0;
    fork
      begin
        push(32'd10, 32'd1, 32'd9,  1'b0, 1'b0, 0);
        push(32'd20, 32'd2, 32'd18, 1'b0, 1'b0, 0);
        push(32'd30, 32'd3, 32'd27, 1'b0, 1'b0, 0);
        push(32'd40, 32'd4, 32'd36, 1'b0, 1'b0, 0);
        in_valid = 1'b0;
      end
      begin
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("in_ready_dropped", {31'b0, saw_block}, 32'd1);

    // Full throughput with out_ready held high
    pop_cyc.delete();
    push(32'd100, 32'd1, 32'd99,  1'b0, 1'b0, 1);
    push(32'd200, 32'd2, 32'd198, 1'b0, 1'b0, 1);
    push(32'd300, 32'd3, 32'd297, 1'b0, 1'b0, 1);
    push(32'd400, 32'd4, 32'd396, 1'b0, 1'b0, 1);
    in_valid = 1'b0;
    drain();
    chk("throughput_count", pop_cyc.size(), 32'd4);
    if (pop_cyc.size() == 4) chk("throughput_span", pop_cyc[3] - pop_cyc[0], 32'd3);

    // Reset while two operand pairs are in flight
    push(32'd50, 32'd7, 32'd43, 1'b0, 1'b0, 0);
    push(32'd60, 32'd8, 32'd52, 1'b0, 1'b0, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    held = 0;
    @(negedge clk);
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_diff", diff, 32'd0);
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
